// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter, round-robin or fixed priority, with one split-transaction slot
module bus_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic breq1,
   input  logic breq2,
   input  logic ssplit,
   input  logic sready,
   output logic bgrant1,
   output logic bgrant2,
   output logic msel,
   output logic split_grant,
   output logic split_pend
);
   typedef enum logic [1:0] {IDLE, BUSY1, BUSY2} state_t;
   state_t r_state;
   logic r_bgrant1, r_bgrant2, r_msel, r_split_grant, r_split_pend, r_split_owner, r_last_owner;
   logic w_resume, w_elig1, w_elig2, w_go, w_pick, w_own, w_own_req, w_split;
   // owner encoding everywhere: 0 = M1, 1 = M2
   always_comb begin
      w_resume  = r_split_pend && sready;
      w_elig1   = breq1 && !(r_split_pend && !r_split_owner);
      w_elig2   = breq2 && !(r_split_pend && r_split_owner);
      w_go      = w_resume || w_elig1 || w_elig2;
      w_pick    = w_resume ? r_split_owner :
                  (w_elig1 && w_elig2) ? ((RR_EN != 0) ? !r_last_owner : 1'b0) : w_elig2;
      w_own     = r_state == BUSY2;
      w_own_req = w_own ? breq2 : breq1;
      w_split   = ssplit && !r_split_pend;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_bgrant1     <= 1'b0;
         r_bgrant2     <= 1'b0;
         r_msel        <= 1'b0;
         r_split_grant <= 1'b0;
         r_split_pend  <= 1'b0;
         r_split_owner <= 1'b0;
         r_last_owner  <= 1'b1;
      end else begin
         r_split_grant <= 1'b0;
         if (r_state == IDLE) begin
            if (w_go) begin
               r_state      <= w_pick ? BUSY2 : BUSY1;
               r_bgrant1    <= !w_pick;
               r_bgrant2    <= w_pick;
               r_msel       <= w_pick;
               r_last_owner <= w_pick;
            end
            if (w_resume) begin
               r_split_grant <= 1'b1;
               r_split_pend  <= 1'b0;
            end
         end else if (w_split || !w_own_req) begin
            // a split beats a release in the same cycle; every grant ends in IDLE for turnaround
            r_state   <= IDLE;
            r_bgrant1 <= 1'b0;
            r_bgrant2 <= 1'b0;
            if (w_split) begin
               r_split_pend  <= 1'b1;
               r_split_owner <= w_own;
            end
         end
      end
   end
   assign bgrant1     = r_bgrant1;
   assign bgrant2     = r_bgrant2;
   assign msel        = r_msel;
   assign split_grant = r_split_grant;
   assign split_pend  = r_split_pend;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with M1 highest.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports breq1 and breq2, input, 1 each, bus request from master 1 and master 2; a master holds its request for the whole transaction.
REQ-005 SHALL have ports bgrant1 and bgrant2, output, 1 each, bus grant to master 1 and master 2; the two are never high together.
REQ-006 SHALL have port msel, output, 1, bus mux select: 0 = M1 drives the bus, 1 = M2 drives the bus.
REQ-007 SHALL have port ssplit, input, 1, split indication from the split-capable slave.
REQ-008 SHALL have port sready, input, 1, split-capable slave ready to resume.
REQ-009 SHALL have port split_grant, output, 1, one-cycle pulse to the split slave when the split owner is re-granted.
REQ-010 SHALL have port split_pend, output, 1, a split transaction is outstanding.

Function
REQ-011 SHALL implement states IDLE, BUSY1 and BUSY2, plus registers split_pend, split_owner and last_owner.
REQ-012 SHALL drive bgrant1 = (state==BUSY1) and bgrant2 = (state==BUSY2); msel SHALL follow the current owner and hold its last value in IDLE.
REQ-013 In IDLE with split_pend=1 and sready=1, SHALL go to BUSY<split_owner>, pulse split_grant for that one cycle, and clear split_pend; this has priority over all breq.
REQ-014 In IDLE otherwise, SHALL treat breqx as eligible only if no split is pending for master x, i.e. not (split_pend=1 and split_owner=x).
REQ-015 If exactly one master is eligible, SHALL go to its BUSY state; grant is high on the first clock edge after the request is sampled (1-cycle latency).
REQ-016 If both masters are eligible: with RR_EN=1, SHALL grant the master that is not last_owner; with RR_EN=0, SHALL grant M1.
REQ-017 On entry to any BUSY state, SHALL set last_owner to the granted master.
REQ-018 In BUSYx with ssplit=1 and split_pend=0, SHALL set split_pend=1 and split_owner=x, then go to IDLE.
REQ-019 In BUSYx with ssplit=0 and breqx=0, SHALL go to IDLE.
REQ-020 In BUSYx with ssplit=1 and breqx=0 in the same cycle, the split SHALL win (REQ-018).
REQ-021 In BUSYx with ssplit=1 and split_pend=1 (only one split slot), SHALL ignore ssplit and keep the grant.
REQ-022 SHALL always pass through at least one IDLE cycle between two grants (bus turnaround).
REQ-023 SHALL ignore ssplit in IDLE, and ignore sready when split_pend=0 or the state is not IDLE.
REQ-024 A master whose split is pending SHALL still get its resume grant even if its breq is low.

Reset
REQ-025 While rst=1 (asynchronous), SHALL force: state = IDLE, bgrant1 = bgrant2 = 0, msel = 0, split_grant = 0, split_pend = 0, split_owner = M1, last_owner = M2 (so M1 wins the first tie).
REQ-026 Reset asserted mid-transaction or with a split pending SHALL drop all grants immediately and discard the pending split.

Verification
REQ-027 Bench SHALL cover: breq1=1 only -> bgrant1=1 and msel=0 one cycle later; breq1=0 -> bgrant1=0 next cycle, then IDLE.
REQ-028 Bench SHALL cover: breq1 and breq2 held high with RR_EN=1, each master releasing after 4 cycles -> grant sequence M1, M2, M1, with exactly one IDLE cycle between grants; with RR_EN=0 -> M1 is re-granted each time.
REQ-029 Bench SHALL cover: M1 granted, ssplit=1 -> split_pend=1 and bgrant1=0 next cycle; breq2=1 -> M2 granted; breq1 stays high but M1 is not granted.
REQ-030 Bench SHALL cover: split pending for M1, M2 releases the bus, sready=1 -> bgrant1=1 and split_grant high for exactly 1 cycle, split_pend=0; this holds even when breq2=1 in the same cycle.
REQ-031 Bench SHALL cover: split pending for M1, M2 granted, ssplit=1 -> ignored, bgrant2 stays 1; and ssplit=1 with breq1=0 in the same cycle -> split recorded.
REQ-032 Bench SHALL cover: rst pulsed while BUSY2 with split pending -> all outputs 0 asynchronously; after release, breq1 and breq2 both high -> M1 granted first.
